// File: rtl/tug_of_war_ctrl_pkg.sv
// Shared constants for the tug-of-war game controller.
// FSM state codes and winner codes.
package tug_pkg;

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

endpackage

// File: rtl/tug_of_war_ctrl_if.sv
// Key inputs and display outputs of the tug-of-war controller.
// master drives the keys; slave is the controller.
interface tug_of_war_ctrl_if #(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
);
  logic                L;
  logic                R;
  logic [N_LIGHTS-1:0] lights;
  logic [SCORE_W-1:0]  left_score;
  logic [SCORE_W-1:0]  right_score;
  logic [1:0]          winner;
  logic                game_over;

  modport master (
    output L, R,
    input  lights, left_score, right_score,
    input  winner, game_over
  );

  modport slave (
    input  L, R,
    output lights, left_score, right_score,
    output winner, game_over
  );
endinterface

// File: rtl/tug_of_war_ctrl_key_press.sv
// Level-to-pulse converter for one synchronised player key.
// Emits a one-cycle pulse on each rising level.
module key_press (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);
  logic key_q;

  always_ff @(posedge clk) begin
    if (reset) key_q <= 1'b0;
    else       key_q <= key_i;
  end

  assign press_o = key_i & ~key_q;
endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war controller: light position, scoring, hold and match end.
// Outputs depend only on registered state.
module tug_of_war_ctrl
  import tug_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  tug_of_war_ctrl_if.slave bus
);
  localparam int SCORE_W = $clog2(MAX_SCORE+1);
  localparam int PW = $clog2(N_LIGHTS);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] CENTRE = PW'(N_LIGHTS/2);
  localparam logic [PW-1:0] LEFT_END = PW'(N_LIGHTS-1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES-1);
  localparam logic [SCORE_W-1:0] LAST = SCORE_W'(MAX_SCORE-1);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  logic press_l, press_r;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SCORE_W-1:0] lsc_q, lsc_d;
  logic [SCORE_W-1:0] rsc_q, rsc_d;
  logic [1:0] win_q, win_d;
  logic mv_l, mv_r;

  key_press u_kl (
    .clk    (clk),
    .reset  (reset),
    .key_i  (bus.L),
    .press_o(press_l)
  );

  key_press u_kr (
    .clk    (clk),
    .reset  (reset),
    .key_i  (bus.R),
    .press_o(press_r)
  );

  // Simultaneous presses cancel each other.
  assign mv_l = press_l & ~press_r;
  assign mv_r = press_r & ~press_l;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    lsc_d   = lsc_q;
    rsc_d   = rsc_q;
    win_d   = win_q;
    unique case (1'b1)
      state_q == ST_PLAY: begin
        if (mv_l) begin
          if (pos_q == LEFT_END) begin
            lsc_d   = lsc_q + ONE;
            win_d   = WIN_L;
            cnt_d   = HOLD_LD;
            state_d = (lsc_q == LAST) ? ST_OVER : ST_HOLD;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (mv_r) begin
          if (pos_q == '0) begin
            rsc_d   = rsc_q + ONE;
            win_d   = WIN_R;
            cnt_d   = HOLD_LD;
            state_d = (rsc_q == LAST) ? ST_OVER : ST_HOLD;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end
      state_q == ST_HOLD: begin
        if (cnt_q == '0) begin
          pos_d   = CENTRE;
          win_d   = WIN_NONE;
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PLAY;
      pos_q   <= CENTRE;
      cnt_q   <= '0;
      lsc_q   <= '0;
      rsc_q   <= '0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      lsc_q   <= lsc_d;
      rsc_q   <= rsc_d;
      win_q   <= win_d;
    end
  end

  assign bus.lights = (state_q == ST_PLAY) ?
                      (N_LIGHTS'(1) << pos_q) : '0;
  assign bus.left_score  = lsc_q;
  assign bus.right_score = rsc_q;
  assign bus.winner      = win_q;
  assign bus.game_over   = (state_q == ST_OVER);
endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed self-checking bench for tug_of_war_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_tug_of_war_ctrl;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  tug_of_war_ctrl_if #(.N_LIGHTS(9), .SCORE_W(3)) bus ();

  tug_of_war_ctrl #(
    .N_LIGHTS(9), .MAX_SCORE(7), .HOLD_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_l();
    bus.L = 1'b1; step();
    bus.L = 1'b0; step();
  endtask

  task automatic press_r();
    bus.R = 1'b1; step();
    bus.R = 1'b0; step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lights"}, 32'(bus.lights), 32'h010);
    chk({tag, "_lsc"}, 32'(bus.left_score), 0);
    chk({tag, "_rsc"}, 32'(bus.right_score), 0);
    chk({tag, "_win"}, 32'(bus.winner), 0);
    chk({tag, "_go"}, 32'(bus.game_over), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.L = 1'b0;
    bus.R = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_reset("rst");

    bus.L = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("hold_l", 32'(bus.lights), 32'h020);
    bus.L = 1'b0; step();
    bus.R = 1'b1; step();
    chk("r_back", 32'(bus.lights), 32'h010);
    bus.R = 1'b0; step();

    bus.L = 1'b1; bus.R = 1'b1; step();
    chk("cancel", 32'(bus.lights), 32'h010);
    bus.L = 1'b0; bus.R = 1'b0; step();
    press_r();
    chk("r_one", 32'(bus.lights), 32'h008);
    press_l();
    chk("recentre", 32'(bus.lights), 32'h010);

    for (int i = 0; i < 4; i++) press_l();
    chk("at_end", 32'(bus.lights), 32'h100);
    bus.L = 1'b1; step();
    chk("pt_lsc", 32'(bus.left_score), 1);
    chk("pt_win", 32'(bus.winner), 32'h2);
    chk("hold1", 32'(bus.lights), 0);
    bus.L = 1'b0; step();
    chk("hold2", 32'(bus.lights), 0);
    bus.L = 1'b1; step();
    chk("hold3", 32'(bus.lights), 0);
    bus.L = 1'b0; step();
    chk("hold4", 32'(bus.lights), 0);
    step();
    chk("play_lights", 32'(bus.lights), 32'h010);
    chk("play_win", 32'(bus.winner), 0);
    chk("play_lsc", 32'(bus.left_score), 1);
    chk("play_rsc", 32'(bus.right_score), 0);

    for (int p = 2; p <= 7; p++) begin
      for (int i = 0; i < 5; i++) press_l();
      chk("lsc_run", 32'(bus.left_score), 32'(p));
      if (p < 7) begin
        step(); step(); step();
        chk("run_centre", 32'(bus.lights), 32'h010);
      end
    end
    chk("over_go", 32'(bus.game_over), 1);
    chk("over_lsc", 32'(bus.left_score), 7);
    chk("over_lights", 32'(bus.lights), 0);
    chk("over_win", 32'(bus.winner), 32'h2);
    for (int i = 0; i < 3; i++) begin
      press_l();
      press_r();
    end
    bus.L = 1'b1; bus.R = 1'b1; step();
    bus.L = 1'b0; bus.R = 1'b0; step();
    chk("frz_go", 32'(bus.game_over), 1);
    chk("frz_lsc", 32'(bus.left_score), 7);
    chk("frz_rsc", 32'(bus.right_score), 0);
    chk("frz_lights", 32'(bus.lights), 0);
    chk("frz_win", 32'(bus.winner), 32'h2);
    reset = 1'b1; step();
    reset = 1'b0;
    chk_reset("rst2");

    for (int i = 0; i < 4; i++) press_r();
    chk("r_end", 32'(bus.lights), 32'h001);
    bus.R = 1'b1; step();
    chk("rpt_rsc", 32'(bus.right_score), 1);
    chk("rpt_win", 32'(bus.winner), 32'h1);
    chk("rpt_hold", 32'(bus.lights), 0);
    bus.R = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0;
    chk_reset("rst_hold");
    press_l();
    chk("after_rst", 32'(bus.lights), 32'h020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
